rand_range_gen: RTL

Parametrised pseudo-random source producing uniformly distributed integers in [0, MAX] on a valid/ready stream. It replaces the fixed sum-of-four-LFSRs generator, which produced a non-uniform, unseeded 0..472 value. Consumers such as sprite placement and game logic pull one value per handshake. Range limiting uses rejection sampling on a single maximal-length XNOR LFSR, so the output distribution is uniform.

---
 rtl/lfsr_pkg.sv | 53 +++++
 rtl/lfsr_core.sv | 43 ++++
 rtl/rand_range_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions.
//   lfsr_default_taps(width) : maximal-length XNOR tap mask for widths 3..32
//                              (bit i set => q[i] feeds the XNOR), '0 otherwise
//   REJ_CNT_W                : width of the saturating reject counter
//   fsm_state_e              : output-slot state (EMPTY / FULL)
package lfsr_pkg;

  localparam int unsigned REJ_CNT_W = 16;

  typedef enum logic {
    S_EMPTY,
    S_FULL
  } fsm_state_e;

  function automatic logic [31:0] lfsr_default_taps(input int unsigned width);
    logic [31:0] t;
    case (width)
      3:       t = 32'h0000_0006;
      4:       t = 32'h0000_000C;
      5:       t = 32'h0000_0014;
      6:       t = 32'h0000_0030;
      7:       t = 32'h0000_0060;
      8:       t = 32'h0000_00B8;
      9:       t = 32'h0000_0110;
      10:      t = 32'h0000_0240;
      11:      t = 32'h0000_0500;
      12:      t = 32'h0000_0829;
      13:      t = 32'h0000_100D;
      14:      t = 32'h0000_2015;
      15:      t = 32'h0000_6000;
      16:      t = 32'h0000_D008;
      17:      t = 32'h0001_2000;
      18:      t = 32'h0002_0400;
      19:      t = 32'h0004_0023;
      20:      t = 32'h0009_0000;
      21:      t = 32'h0014_0000;
      22:      t = 32'h0030_0000;
      23:      t = 32'h0042_0000;
      24:      t = 32'h00E1_0000;
      25:      t = 32'h0120_0000;
      26:      t = 32'h0200_0023;
      27:      t = 32'h0400_0013;
      28:      t = 32'h0900_0000;
      29:      t = 32'h1400_0000;
      30:      t = 32'h2000_0029;
      31:      t = 32'h4800_0000;
      32:      t = 32'h8020_0003;
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci XNOR LFSR with synchronous load.
//   clk, reset : clock, synchronous active-high reset (state -> 0)
//   en         : step enable
//   load       : load load_val (priority over en); all-ones is replaced by 0
//   load_val   : seed value
//   q          : current LFSR state
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 9,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH))
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // All-ones is the XNOR lock-up state, so it must never be loaded.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val == '1) ? '0 : load_val;
    end else if (en) begin
      q_d = {q_q[WIDTH-2:0], ~^(q_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/rand_range_gen.sv
// Uniform pseudo-random source in [0, MAX] on a valid/ready stream.
// Out-of-range LFSR states are rejected and counted (saturating).
//   clk, reset : clock, synchronous active-high reset
//   en         : advance enable; low freezes LFSR and counter
//   seed_load  : load seed into the LFSR, drop any pending value
//   seed       : seed value
//   out_valid  : out_data holds an unconsumed value
//   out_ready  : consumer accepts when out_valid && out_ready
//   out_data   : random value, <= MAX while out_valid
//   reject_cnt : saturating count of rejected candidates
module rand_range_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 9,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
  parameter int unsigned      MAX   = 472
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [REJ_CNT_W-1:0] reject_cnt
);

  localparam longint unsigned MAX_L = MAX;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("rand_range_gen: WIDTH must be in 3..32");
  end
  if (!(((64'd1 << (WIDTH - 1)) <= MAX_L) && (MAX_L < (64'd1 << WIDTH)))) begin : g_bad_max
    $error("rand_range_gen: MAX must satisfy 2^(WIDTH-1) <= MAX < 2^WIDTH");
  end
  // A maximal polynomial taps the top bit and has an even tap count.
  if (TAPS[WIDTH-1] != 1'b1 || ($countones(TAPS) % 2) != 0) begin : g_bad_taps
    $error("rand_range_gen: TAPS cannot be maximal-length for WIDTH");
  end

  logic [WIDTH-1:0]     cand;
  fsm_state_e           state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [REJ_CNT_W-1:0] rej_cnt_q, rej_cnt_d;
  logic                 accept, slot_open;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (seed_load),
    .load_val (seed),
    .q        (cand)
  );

  assign accept    = (state_q == S_FULL) && out_ready;
  assign slot_open = (state_q == S_EMPTY) || out_ready;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    rej_cnt_d = rej_cnt_q;
    if (seed_load) begin
      state_d = S_EMPTY;
    end else if (!en) begin
      if (accept) begin
        state_d = S_EMPTY;
      end
    end else if (slot_open) begin
      if (cand <= MAX_W) begin
        state_d = S_FULL;
        data_d  = cand;
      end else begin
        state_d = S_EMPTY;
        if (rej_cnt_q != '1) begin
          rej_cnt_d = rej_cnt_q + REJ_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      data_q    <= '0;
      rej_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign out_valid  = (state_q == S_FULL);
  assign out_data   = data_q;
  assign reject_cnt = rej_cnt_q;

endmodule
